// File: rtl/a78_input_pkg.sv
// Shared types and helpers for the Atari 7800 controller input front end.
// Holds the port-mode encoding, the default charge length and the pot scaling helper.
package a78_input_pkg;

  typedef enum logic {
    PORT_MODE_PADDLE  = 1'b0,
    PORT_MODE_PROLINE = 1'b1
  } port_mode_e;

  localparam int DEFAULT_MAX_LINES = 228;

  // Scanlines needed to charge a pot at this position: (pos * max) >> 8.
  function automatic logic [8:0] scale_pos(input logic [7:0] pos, input logic [8:0] max);
    logic [16:0] prod;
    prod = {9'b0, pos} * {8'b0, max};
    return prod[16:8];
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One emulated paddle pot: latches its charge target while grounded and counts
// scanlines after release, flagging when the line would cross the TIA threshold.
module paddle_channel
  import a78_input_pkg::*;
#(
  parameter int MAX_LINES = DEFAULT_MAX_LINES,
  parameter bit INVERT    = 1'b0
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic       dump_i,
  input  logic       line_tick_i,
  input  logic [7:0] pos_i,
  output logic       charged_o
);

  localparam logic [8:0] MaxLines9 = 9'(MAX_LINES);

  logic [7:0] posEff;
  logic [8:0] target_q, target_d;
  logic [8:0] cnt_q, cnt_d;

  // Target tracks the position only while grounded, so a measurement in flight ignores later position changes.
  always_comb begin
    posEff   = INVERT ? ~pos_i : pos_i;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (dump_i) begin
      target_d = scale_pos(posEff, MaxLines9);
      cnt_d    = 9'd0;
    end else if (line_tick_i && (cnt_q < target_q)) begin
      cnt_d = cnt_q + 9'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      target_q <= MaxLines9;
      cnt_q    <= 9'd0;
    end else begin
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  assign charged_o = (cnt_q >= target_q);

endmodule

// File: rtl/paddle_dump_timer.sv
// Drives the TIA dumped-input lines: four paddle charge timers, with each controller
// port switchable to pass its two ProLine buttons straight through instead.
module paddle_dump_timer
  import a78_input_pkg::*;
#(
  parameter int MAX_LINES = DEFAULT_MAX_LINES,
  parameter bit INVERT    = 1'b0
) (
  input  logic        clk,
  input  logic        RES_n,
  input  logic        dump,
  input  logic        line_tick,
  input  logic [31:0] paddle_pos,
  input  logic [1:0]  port_mode,
  input  logic [3:0]  btn,
  output logic [3:0]  idump
);

  logic [3:0] charged;
  logic [3:0] idump_q, idump_d;

  for (genvar i = 0; i < 4; i++) begin : gen_chan
    paddle_channel #(
      .MAX_LINES (MAX_LINES),
      .INVERT    (INVERT)
    ) u_chan (
      .clk_i       (clk),
      .res_n_i     (RES_n),
      .dump_i      (dump),
      .line_tick_i (line_tick),
      .pos_i       (paddle_pos[8*i +: 8]),
      .charged_o   (charged[i])
    );
  end

  // Counters keep running in ProLine mode, so switching back needs no restart.
  always_comb begin
    idump_d = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (port_mode_e'(port_mode[i/2]) == PORT_MODE_PROLINE) begin
        idump_d[i] = btn[i];
      end else begin
        idump_d[i] = ~dump & charged[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RES_n) begin
      idump_q <= 4'b0000;
    end else begin
      idump_q <= idump_d;
    end
  end

  assign idump = idump_q;

endmodule
